uart_vga_loader: RTL and testbench

Receives a framed byte stream on the UART RX pin and writes the payload into the `uart_vga_ram` display buffer through its byte-wide write port. Sits directly upstream of the VGA debug display and shares its pixel clock. It validates each frame with a sync byte and an XOR checksum, and reports completion or error with single-cycle pulses.

---
 rtl/uart_vga_loader_pkg.sv | 22 ++
 rtl/uart_vga_loader_rx.sv | 111 +++++++++++
 rtl/uart_vga_loader.sv | 137 +++++++++++++
 tb/tb_uart_vga_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_vga_loader_pkg.sv
// Shared constants and state encodings for the UART-to-display-RAM loader.
// Default geometry matches the uart_vga_ram sizing (736 px / 16 rows, 160-bit rows).
package uart_vga_pkg;

  localparam logic [7:0] SYNC_BYTE         = 8'hA5;
  localparam int         DEF_ROWS          = 46;
  localparam int         DEF_BYTES_PER_ROW = 20;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    F_SYNC,
    F_DATA,
    F_CHECK
  } frame_state_t;

endpackage

// File: rtl/uart_vga_loader_rx.sv
// UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
// Emits one-cycle rx_valid (good stop bit) or rx_ferr (stop bit low) at the stop sample.
//
// state   | meaning
// R_IDLE  | waiting for a falling edge on the line
// R_START | timing to mid start bit; high there means glitch
// R_DATA  | sampling 8 data bits LSB first
// R_STOP  | sampling the stop bit
module uart_rx
  import uart_vga_pkg::*;
#(
  parameter int CLKS_PER_BIT = 745
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_d, ferr_d;
  logic          meta_q, sync_q, prev_q;

  // Synchronizer flops reset to the idle-high line level so reset release is not a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= R_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      meta_q   <= rx_line;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_valid <= valid_d;
      rx_ferr  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = R_START;
          cnt_d   = HALF;
        end
      end
      R_START: begin
        if (cnt_q == '0) begin
          if (sync_q) begin
            state_d = R_IDLE;
          end else begin
            state_d = R_DATA;
            cnt_d   = FULL;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync_q, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) state_d = R_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      R_STOP: begin
        // Leave at the stop sample so back-to-back bytes never lose their start edge.
        if (cnt_q == '0) begin
          valid_d = sync_q;
          ferr_d  = !sync_q;
          state_d = R_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/uart_vga_loader.sv
// Frame loader: sync byte, N payload bytes written to display RAM, XOR checksum byte.
// Reports completion/error with one-cycle pulses; aborts on stop-bit error or inter-byte timeout.
//
// state   | meaning
// F_SYNC  | hunting for the sync byte, other bytes dropped
// F_DATA  | writing payload bytes to RAM
// F_CHECK | waiting for the checksum byte
module uart_vga_loader
  import uart_vga_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 745,
  parameter int ROWS          = DEF_ROWS,
  parameter int BYTES_PER_ROW = DEF_BYTES_PER_ROW,
  parameter int TIMEOUT       = 2 ** 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] write_address,
  output logic [7:0]  ram_in,
  output logic        we,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int            N         = ROWS * BYTES_PER_ROW;
  localparam int            CW        = (N > 1) ? $clog2(N) : 1;
  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(N - 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT - 1);

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_ferr;

  frame_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] idle_q;
  logic          timeout;
  logic [31:0]   addr_d;
  logic [7:0]    data_d;
  logic          we_d, done_d, err_d;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_line (uart_rx),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  // Idle timer counts down between bytes; parked at full load while hunting for sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= IDLE_LOAD;
    end else if (state_q == F_SYNC || rx_valid) begin
      idle_q <= IDLE_LOAD;
    end else if (idle_q != '0) begin
      idle_q <= idle_q - TW'(1);
    end
  end

  assign timeout = (state_q != F_SYNC) && (idle_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= F_SYNC;
      cnt_q         <= '0;
      csum_q        <= '0;
      write_address <= '0;
      ram_in        <= '0;
      we            <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      write_address <= addr_d;
      ram_in        <= data_d;
      we            <= we_d;
      frame_done    <= done_d;
      frame_err     <= err_d;
      busy          <= (state_d != F_SYNC);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    addr_d  = write_address;
    data_d  = ram_in;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      F_SYNC: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = F_DATA;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      F_DATA: begin
        if (rx_ferr || timeout) begin
          err_d   = 1'b1;
          state_d = F_SYNC;
        end else if (rx_valid) begin
          we_d   = 1'b1;
          data_d = rx_byte;
          addr_d = 32'(cnt_q);
          csum_d = csum_q ^ rx_byte;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = F_CHECK;
        end
      end
      F_CHECK: begin
        if (rx_ferr || timeout) begin
          err_d   = 1'b1;
          state_d = F_SYNC;
        end else if (rx_valid) begin
          done_d  = (rx_byte == csum_q);
          err_d   = (rx_byte != csum_q);
          state_d = F_SYNC;
        end
      end
      default: state_d = F_SYNC;
    endcase
  end

endmodule

// File: tb/tb_uart_vga_loader.sv
// Scoreboard bench: stimulus tasks queue expected writes/pulses per frame, a monitor pops and compares.
module tb_uart_vga_loader;

  localparam int CPB     = 16;
  localparam int ROWS    = 4;
  localparam int BPR     = 5;
  localparam int N       = ROWS * BPR;
  localparam int TIMEOUT = 2000;
  localparam int K_WR    = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] write_address;
  logic [7:0]  ram_in;
  logic        we, frame_done, frame_err, busy;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  uart_vga_loader #(
    .CLKS_PER_BIT (CPB),
    .ROWS         (ROWS),
    .BYTES_PER_ROW(BPR),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .write_address(write_address),
    .ram_in       (ram_in),
    .we           (we),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every DUT output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst && (we || frame_done || frame_err)) begin
      if (frame_done || frame_err) chk("done_err_exclusive", frame_done & frame_err, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: we=%0d done=%0d err=%0d addr=%0d", we, frame_done,
                 frame_err, write_address);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (we) begin
          chk("write_kind", K_WR, e.kind);
          chk("write_address", write_address, e.addr);
          chk("ram_in", ram_in, e.data);
        end else if (frame_done) begin
          chk("pulse_kind_done", K_DONE, e.kind);
        end else begin
          chk("pulse_kind_err", K_ERR, e.kind);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop;
    wait_clks(CPB);
    uart_rx = 1'b1;
    wait_clks(stop ? $urandom_range(0, 6) : CPB);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 4000 && exp_q.size() != 0; k++) @(negedge clk);
    wait_clks(4);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_we"}, we, 0);
    chk({name, "_done"}, frame_done, 0);
    chk({name, "_err"}, frame_err, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_addr"}, write_address, 0);
    chk({name, "_data"}, ram_in, 0);
  endtask

  // Full frame: payload is i&0xFF when pattern is set, random otherwise.
  task automatic send_frame(input bit pattern, input bit bad_sum);
    logic [7:0] pl[$];
    logic [7:0] x;
    logic [7:0] sum_byte;
    x = 8'h00;
    for (int i = 0; i < N; i++) begin
      logic [7:0] b;
      b = pattern ? 8'(i) : 8'($urandom);
      pl.push_back(b);
      x ^= b;
      push_ev(K_WR, i, b);
    end
    push_ev(bad_sum ? K_ERR : K_DONE, 0, 0);
    sum_byte = bad_sum ? (x ^ 8'($urandom_range(1, 255))) : x;
    send_byte(8'hA5, 1'b1);
    foreach (pl[i]) send_byte(pl[i], 1'b1);
    send_byte(sum_byte, 1'b1);
  endtask

  // Sync plus the first count payload bytes; the caller decides how the frame ends.
  task automatic send_prefix(input int count);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < count; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      push_ev(K_WR, i, b);
      send_byte(b, 1'b1);
    end
  endtask

  initial begin
    wait_clks(5);
    check_outputs_zero("reset");
    rst = 1'b1;
    wait_clks(5);

    // Short low pulse in idle must not produce a byte.
    uart_rx = 1'b0;
    wait_clks(4);
    uart_rx = 1'b1;
    wait_clks(3 * CPB);
    chk("glitch_busy", busy, 0);
    chk("glitch_queue", exp_q.size(), 0);

    send_frame(1'b1, 1'b0);
    drain("pattern_frame");
    chk("pattern_busy_after", busy, 0);

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    chk("garbage_busy", busy, 0);
    send_frame(1'b0, 1'b0);
    drain("garbage_then_frame");

    send_frame(1'b0, 1'b1);
    drain("bad_checksum");
    send_frame(1'b0, 1'b0);
    drain("good_after_bad");

    // Framing error while hunting for sync is ignored.
    send_byte(8'h3C, 1'b0);
    drain("ferr_in_sync");

    send_prefix(10);
    push_ev(K_ERR, 0, 0);
    send_byte(8'h77, 1'b0);
    drain("stop_bit_error");
    chk("stop_err_busy", busy, 0);

    send_prefix(6);
    wait_clks(CPB);
    chk("stall_busy_high", busy, 1);
    push_ev(K_ERR, 0, 0);
    wait_clks(TIMEOUT + 200);
    drain("timeout");
    chk("timeout_busy", busy, 0);

    send_prefix(8);
    drain("pre_reset_writes");
    uart_rx = 1'b0;
    wait_clks(3 * CPB);
    rst = 1'b0;
    uart_rx = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    wait_clks(3);
    rst = 1'b1;
    wait_clks(3 * CPB);
    chk("post_reset_queue", exp_q.size(), 0);
    send_frame(1'b0, 1'b0);
    drain("frame_after_reset");

    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, 1'($urandom_range(0, 1)));
      drain("random_frame");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
